// File: rtl/lcd_byte_writer.sv
// HD44780-style byte writer: setup / enable / hold bus sequencing, execution wait, one-cycle done pulse.
// Build option `LCD_BUSY_POLL_EN swaps the fixed execution wait for a busy-flag poll loop.
module lcd_byte_writer #(
  parameter int T_SETUP     = 2,
  parameter int T_EHIGH     = 12,
  parameter int T_HOLD      = 2,
  parameter int T_EXEC      = 2000,
  parameter int T_EXEC_LONG = 80000,
  parameter int CNT_W       = 17
) (
  input  logic       sm_clk,
  input  logic       reset,
  input  logic       start_LCD_writer,
  input  logic [7:0] DB,
  input  logic       is_command,
  output logic       LCD_writer_finished,
  output logic       busy,
  output logic       lcd_e,
  output logic       lcd_rs,
  output logic       lcd_rw,
  output logic [7:0] lcd_db
`ifdef LCD_BUSY_POLL_EN
  ,
  output logic       lcd_db_oe,
  input  logic [7:0] lcd_db_in
`endif
);

  typedef enum logic [3:0] {
    IDLE, SETUP, E_HIGH, HOLD, EXEC_WAIT, DONE, POLL_SETUP, POLL_EHIGH, POLL_HOLD
  } state_t;

  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(T_SETUP - 1);
  localparam logic [CNT_W-1:0] EHIGH_LAST = CNT_W'(T_EHIGH - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(T_HOLD - 1);
  localparam logic [CNT_W-1:0] LONG_LAST  = CNT_W'(T_EXEC_LONG - 1);

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [7:0]       db_l;
  logic             cmd_l;
  logic             latch;

`ifdef LCD_BUSY_POLL_EN
  logic [CNT_W-1:0] poll_cnt, poll_cnt_n;
  logic             bsy_flag, bsy_flag_n;
  logic             polling;
  assign polling = (state == POLL_SETUP) || (state == POLL_EHIGH) || (state == POLL_HOLD);
`else
  localparam logic [CNT_W-1:0] EXEC_LAST = CNT_W'(T_EXEC - 1);
  logic long_exec;
  // Clear display (0x01) and return home (0x02/0x03) need the long execution time
  assign long_exec = cmd_l && (db_l == 8'h01 || db_l[7:1] == 7'h01);
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    latch   = 1'b0;
`ifdef LCD_BUSY_POLL_EN
    poll_cnt_n = poll_cnt + 1'b1;
    bsy_flag_n = bsy_flag;
`endif
    case (state)
      IDLE: begin
        cnt_n = '0;
        if (start_LCD_writer) begin
          state_n = SETUP;
          latch   = 1'b1;
        end
      end
      SETUP:
        if (cnt == SETUP_LAST) begin
          state_n = E_HIGH;
          cnt_n   = '0;
        end
      E_HIGH:
        if (cnt == EHIGH_LAST) begin
          state_n = HOLD;
          cnt_n   = '0;
        end
      HOLD:
        if (cnt == HOLD_LAST) begin
`ifdef LCD_BUSY_POLL_EN
          state_n    = POLL_SETUP;
          poll_cnt_n = '0;
`else
          state_n    = EXEC_WAIT;
`endif
          cnt_n = '0;
        end
`ifdef LCD_BUSY_POLL_EN
      POLL_SETUP:
        if (cnt == SETUP_LAST) begin
          state_n = POLL_EHIGH;
          cnt_n   = '0;
        end
      POLL_EHIGH:
        if (cnt == EHIGH_LAST) begin
          state_n    = POLL_HOLD;
          cnt_n      = '0;
          bsy_flag_n = lcd_db_in[7];
        end
      POLL_HOLD:
        if (cnt == HOLD_LAST) begin
          state_n = bsy_flag ? POLL_SETUP : DONE;
          cnt_n   = '0;
        end
`else
      EXEC_WAIT:
        if (cnt == (long_exec ? LONG_LAST : EXEC_LAST)) begin
          state_n = DONE;
          cnt_n   = '0;
        end
`endif
      DONE: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
`ifdef LCD_BUSY_POLL_EN
    // A controller that never clears its busy flag must not hang the sequencer
    if (polling && poll_cnt == LONG_LAST) begin
      state_n = DONE;
      cnt_n   = '0;
    end
`endif
  end

  // Outputs are registered from the current state, so the bus lags the state by one edge
  always_ff @(posedge sm_clk or negedge reset) begin
    if (!reset) begin
      state               <= IDLE;
      cnt                 <= '0;
      busy                <= 1'b0;
      lcd_e               <= 1'b0;
      lcd_rs              <= 1'b0;
      lcd_db              <= 8'h00;
      LCD_writer_finished <= 1'b0;
`ifdef LCD_BUSY_POLL_EN
      poll_cnt  <= '0;
      bsy_flag  <= 1'b0;
      lcd_rw    <= 1'b0;
      lcd_db_oe <= 1'b1;
`endif
    end else begin
      state               <= state_n;
      cnt                 <= cnt_n;
      busy                <= (state_n != IDLE);
      LCD_writer_finished <= (state == DONE);
      if (state == SETUP || state == E_HIGH || state == HOLD || state == EXEC_WAIT) begin
        lcd_rs <= ~cmd_l;
        lcd_db <= db_l;
      end
`ifdef LCD_BUSY_POLL_EN
      lcd_e     <= (state == E_HIGH) || (state == POLL_EHIGH);
      if (polling) lcd_rs <= 1'b0;
      lcd_rw    <= polling;
      lcd_db_oe <= ~polling;
      poll_cnt  <= poll_cnt_n;
      bsy_flag  <= bsy_flag_n;
`else
      lcd_e     <= (state == E_HIGH);
`endif
    end
  end

`ifndef LCD_BUSY_POLL_EN
  assign lcd_rw = 1'b0;
`endif

  always_ff @(posedge sm_clk) begin
    if (latch) begin
      db_l  <= DB;
      cmd_l <= is_command;
    end
  end

endmodule

// File: tb/tb_lcd_byte_writer.sv
// Randomized bench for lcd_byte_writer against a per-transaction timing model.
// Honors `LCD_BUSY_POLL_EN (busy flag read back as 0, so one poll loop per write).
module tb_lcd_byte_writer;

  localparam int TS = 2;
  localparam int TE = 12;
  localparam int TH = 2;
  localparam int TX = 40;
  localparam int TL = 300;

  logic       sm_clk = 1'b0;
  logic       reset;
  logic       start_LCD_writer;
  logic [7:0] DB;
  logic       is_command;
  logic       LCD_writer_finished, busy, lcd_e, lcd_rs, lcd_rw;
  logic [7:0] lcd_db;
`ifdef LCD_BUSY_POLL_EN
  logic       lcd_db_oe;
`endif

  lcd_byte_writer #(
    .T_SETUP(TS), .T_EHIGH(TE), .T_HOLD(TH), .T_EXEC(TX), .T_EXEC_LONG(TL), .CNT_W(17)
  ) dut (
    .sm_clk(sm_clk),
    .reset(reset),
    .start_LCD_writer(start_LCD_writer),
    .DB(DB),
    .is_command(is_command),
    .LCD_writer_finished(LCD_writer_finished),
    .busy(busy),
    .lcd_e(lcd_e),
    .lcd_rs(lcd_rs),
    .lcd_rw(lcd_rw),
    .lcd_db(lcd_db)
`ifdef LCD_BUSY_POLL_EN
    ,
    .lcd_db_oe(lcd_db_oe),
    .lcd_db_in(8'h00)
`endif
  );

  always #5 sm_clk = ~sm_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Execution phase length for a write, straight from the command table
  function automatic int exp_exec(input logic [7:0] d, input logic c);
`ifdef LCD_BUSY_POLL_EN
    return TS + TE + TH;
`else
    if (c && (d == 8'h01 || d == 8'h02 || d == 8'h03)) return TL;
    return TX;
`endif
  endfunction

  // Reference model: edge count, accepting edge and the latched transaction
  int         cyc = 0;
  int         acc = 0;
  bit         active = 1'b0;
  bit         seen = 1'b0;
  logic [7:0] m_db = 8'h00;
  logic       m_cmd = 1'b0;

  always @(posedge sm_clk or negedge reset) begin
    if (!reset) begin
      active = 1'b0;
      seen   = 1'b0;
    end else begin
      cyc++;
      if (start_LCD_writer &&
          (!active || cyc - acc >= TS + TE + TH + exp_exec(m_db, m_cmd) + 2)) begin
        acc    = cyc;
        m_db   = DB;
        m_cmd  = is_command;
        active = 1'b1;
        seen   = 1'b1;
      end
    end
  end

  always @(negedge sm_clk) begin
    int  j, n;
    bit  pw;
    j  = cyc - acc;
    n  = TS + TE + TH + exp_exec(m_db, m_cmd);
    pw = 1'b0;
    if (!reset) begin
      check("rst_e", lcd_e, 0);
      check("rst_fin", LCD_writer_finished, 0);
      check("rst_busy", busy, 0);
      check("rst_rs", lcd_rs, 0);
      check("rst_db", lcd_db, 0);
      check("rst_rw", lcd_rw, 0);
    end else if (active && j <= n + 1) begin
`ifdef LCD_BUSY_POLL_EN
      pw = (j >= TS + TE + TH + 1) && (j <= n);
      check("e", lcd_e, (j >= TS + 1 && j <= TS + TE) ||
                        (j >= 2 * TS + TE + TH + 1 && j <= 2 * TS + 2 * TE + TH));
      check("oe", lcd_db_oe, !pw);
`else
      check("e", lcd_e, (j >= TS + 1 && j <= TS + TE));
`endif
      check("rw", lcd_rw, pw);
      check("fin", LCD_writer_finished, j == n + 1);
      check("busy", busy, j <= n);
      if (j >= 1 && j <= TS + TE + TH) begin
        check("rs", lcd_rs, !m_cmd);
        check("db", lcd_db, m_db);
      end
    end else begin
      check("idle_e", lcd_e, 0);
      check("idle_fin", LCD_writer_finished, 0);
      check("idle_busy", busy, 0);
      check("idle_rw", lcd_rw, 0);
      if (!seen) begin
        check("idle_rs", lcd_rs, 0);
        check("idle_db", lcd_db, 0);
      end
    end
  end

  // Called just after a negedge with the DUT idle; returns on the negedge that sees finished
  task automatic do_write(input logic [7:0] d, input logic c, input bit spur);
    int lat;
    int exp_lat;
    exp_lat = TS + TE + TH + exp_exec(d, c) + 1;
    DB = d;
    is_command = c;
    start_LCD_writer = 1'b1;
    @(negedge sm_clk);
    start_LCD_writer = 1'b0;
    lat = 0;
    while (LCD_writer_finished !== 1'b1 && lat < 2000) begin
      if (spur) begin
        start_LCD_writer = ($urandom_range(0, 7) == 0);
        DB = 8'($urandom);
        is_command = 1'($urandom);
      end
      @(negedge sm_clk);
      lat++;
    end
    start_LCD_writer = 1'b0;
    check("latency", lat, exp_lat);
  endtask

  initial begin
    logic [7:0] d;
    logic       c;
    reset = 1'b0;
    start_LCD_writer = 1'b0;
    DB = 8'h00;
    is_command = 1'b0;
    repeat (3) @(negedge sm_clk);
    check("init_busy", busy, 0);
    check("init_e", lcd_e, 0);
    reset = 1'b1;
    @(negedge sm_clk);

    do_write(8'h41, 1'b0, 1'b1);
    do_write(8'h01, 1'b1, 1'b0);
    @(negedge sm_clk);
    do_write(8'h03, 1'b1, 1'b0);
    do_write(8'h38, 1'b1, 1'b1);
    do_write(8'h02, 1'b1, 1'b0);
    do_write(8'h01, 1'b0, 1'b1);

    // Abort a write while E is high
    DB = 8'h41;
    is_command = 1'b0;
    start_LCD_writer = 1'b1;
    @(negedge sm_clk);
    start_LCD_writer = 1'b0;
    repeat (TS + 6) @(negedge sm_clk);
    check("abort_e_before", lcd_e, 1);
    #2 reset = 1'b0;
    #1;
    check("abort_e", lcd_e, 0);
    check("abort_busy", busy, 0);
    check("abort_rs", lcd_rs, 0);
    check("abort_db", lcd_db, 0);
    repeat (2) @(negedge sm_clk);
    reset = 1'b1;
    repeat (TX + 30) @(negedge sm_clk);
    do_write(8'h41, 1'b0, 1'b0);

    for (int i = 0; i < 24; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge sm_clk);
      d = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(1, 3)) : 8'($urandom);
      c = 1'($urandom);
      do_write(d, c, 1'($urandom));
    end

    repeat (4) @(negedge sm_clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
